// File: rtl/scanline_writer_pkg.sv
// Shared definitions for the scanline_writer block and the scanline_buffer chain it feeds:
// writer state encodings and default geometry.
package scanline_writer_pkg;

    localparam int DEFAULT_REGISTER_WIDTH = 8;
    localparam int DEFAULT_BUFFER_LENGTH  = 512;
    localparam int DEFAULT_COUNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/scanline_writer_if.sv
// Buffer-side bus between the writer (master) and a scanline_buffer chain (slave).
interface scanline_writer_if
    import scanline_writer_pkg::*;
#(
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH
);
    logic [REGISTER_WIDTH-1:0] data_out;
    logic                      valid_out;
    logic                      enable_out;
    logic                      sol;
    logic                      eol;
    logic                      eof;
    logic                      stall;

    modport master (
        output data_out, valid_out, enable_out, sol, eol, eof,
        input  stall
    );

    modport slave (
        input  data_out, valid_out, enable_out, sol, eol, eof,
        output stall
    );
endinterface

// File: rtl/scanline_writer_raster_counter.sv
// Raster position tracker: x/y counters that wrap at line and frame ends, plus the
// sol/eol/eof comparisons for the pixel about to be accepted.
module scanline_writer_raster_counter
    import scanline_writer_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [COUNT_WIDTH-1:0] len,
    input  logic [COUNT_WIDTH-1:0] lines,
    output logic [COUNT_WIDTH-1:0] x_pos,
    output logic [COUNT_WIDTH-1:0] y_pos,
    output logic                   sol,
    output logic                   eol,
    output logic                   eof
);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    assign sol = (x_pos == '0);
    assign eol = (x_pos == len - ONE);
    assign eof = eol && (y_pos == lines - ONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (advance) begin
            if (eol) begin
                x_pos <= '0;
                y_pos <= eof ? '0 : y_pos + ONE;
            end else begin
                x_pos <= x_pos + ONE;
            end
        end
    end
endmodule

// File: rtl/scanline_writer.sv
// Pixel-stream to scanline_buffer writer: accepts raster pixels, drives the buffer chain
// with 1-cycle registered outputs, and flushes the chain with enable-only cycles at frame end.
module scanline_writer
    import scanline_writer_pkg::*;
#(
    parameter int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
    parameter int BUFFER_LENGTH  = DEFAULT_BUFFER_LENGTH,
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               length,
    input  logic [COUNT_WIDTH-1:0]    num_lines,
    input  logic [REGISTER_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    scanline_writer_if.master         buf_bus,
    output logic [COUNT_WIDTH-1:0]    x_pos,
    output logic [COUNT_WIDTH-1:0]    y_pos,
    output logic                      busy,
    output logic                      done
);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    writer_state_t          state, state_next;
    logic [COUNT_WIDTH-1:0] len_q, lines_q, flush_cnt, len_clamped;
    logic                   accept, take_start;
    logic                   at_sol, at_eol, at_eof;

    // Lines longer than the downstream buffers are clamped silently.
    assign len_clamped = (length > 32'(BUFFER_LENGTH)) ? COUNT_WIDTH'(BUFFER_LENGTH)
                                                       : length[COUNT_WIDTH-1:0];

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    scanline_writer_raster_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_raster_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (take_start),
        .advance (accept),
        .len     (len_q),
        .lines   (lines_q),
        .x_pos   (x_pos),
        .y_pos   (y_pos),
        .sol     (at_sol),
        .eol     (at_eol),
        .eof     (at_eof)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        take_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_next = (len_clamped == '0 || num_lines == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = !buf_bus.stall;
                if (in_valid && !buf_bus.stall && at_eof) state_next = FLUSH;
            end
            FLUSH: begin
                if (!buf_bus.stall && flush_cnt == len_q - ONE) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            lines_q   <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (take_start) begin
                len_q   <= len_clamped;
                lines_q <= num_lines;
            end
            if (state == FLUSH) begin
                if (!buf_bus.stall) flush_cnt <= flush_cnt + ONE;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Buffer-side outputs are registered; data_out holds its value between accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_bus.data_out   <= '0;
            buf_bus.valid_out  <= 1'b0;
            buf_bus.enable_out <= 1'b0;
            buf_bus.sol        <= 1'b0;
            buf_bus.eol        <= 1'b0;
            buf_bus.eof        <= 1'b0;
        end else begin
            buf_bus.valid_out  <= accept;
            buf_bus.enable_out <= accept || (state == FLUSH && !buf_bus.stall);
            buf_bus.sol        <= accept && at_sol;
            buf_bus.eol        <= accept && at_eol;
            buf_bus.eof        <= accept && at_eof;
            if (accept) buf_bus.data_out <= in_data;
        end
    end
endmodule

// File: tb/tb_scanline_writer.sv
// Scoreboard bench for scanline_writer: the driver queues expected pixels/flags as they are
// accepted, and a monitor pops and compares whenever valid_out is seen.
module tb_scanline_writer;

    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       eol;
        logic       eof;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] length = '0;
    logic [15:0] num_lines = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_pos, y_pos;
    logic        busy, done;

    int   vectors = 0;
    int   miscompares = 0;
    int   mon_flush = 0;
    int   mon_done = 0;
    int   mon_activity = 0;
    exp_t exp_q[$];

    scanline_writer_if #(.REGISTER_WIDTH(8)) bus ();

    scanline_writer #(
        .REGISTER_WIDTH (8),
        .BUFFER_LENGTH  (512),
        .COUNT_WIDTH    (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .num_lines (num_lines),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_bus   (bus),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int idx, input int seed);
        return 8'((idx * 13 + seed * 31) & 255);
    endfunction

    // Monitor: outputs are registered, so sampling on the falling edge is stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.valid_out || bus.enable_out) mon_activity++;
            if (bus.enable_out && !bus.valid_out) mon_flush++;
            if (done) mon_done++;
            if (bus.valid_out) begin
                check("valid_has_enable", bus.enable_out, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {bus.data_out, bus.sol, bus.eol, bus.eof}, e);
                end
            end
        end
    end

    // One full frame; stall_at/gap_at/abort_at select a pixel index for that event (-1 = none).
    task automatic drive_frame(input int len, input int lines, input int eff, input int stall_at,
                               input int gap_at, input int abort_at, input int seed);
        int idx, total, guard, flush0, done0;
        exp_t e;
        total  = eff * lines;
        idx    = 0;
        guard  = 0;
        flush0 = mon_flush;
        done0  = mon_done;
        @(negedge clock);
        start = 1'b1; length = 32'(len); num_lines = 16'(lines);
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        while (idx < total && guard < 4 * total + 20) begin
            guard++;
            if (idx == abort_at) begin
                check("abort_x", x_pos, idx % eff);
                check("abort_y", y_pos, idx / eff);
                reset = 1'b1; in_valid = 1'b1; in_data = pix(idx, seed);
                @(negedge clock); #2;
                check("abort_outputs", {bus.valid_out, bus.enable_out, bus.sol, bus.eol,
                                        bus.eof, busy, done, in_ready}, 0);
                check("abort_data", bus.data_out, 0);
                check("abort_pos", {x_pos, y_pos}, 0);
                check("abort_queue", exp_q.size(), 0);
                reset = 1'b0; in_valid = 1'b0;
                repeat (6) @(negedge clock);
                #2;
                check("abort_no_done", mon_done - done0, 0);
                check("abort_idle", busy, 1'b0);
                return;
            end else if (idx == stall_at) begin
                stall_at = -1;
                bus.stall = 1'b1; in_valid = 1'b1; in_data = pix(idx, seed);
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("stall_ready", in_ready, 1'b0);
                    check("stall_xpos", x_pos, idx % eff);
                    @(negedge clock);
                    check("stall_enable", {bus.valid_out, bus.enable_out}, 0);
                end
                bus.stall = 1'b0;
            end else if (idx == gap_at) begin
                gap_at = -1;
                in_valid = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clock);
                    check("gap_outputs", {bus.valid_out, bus.enable_out}, 0);
                end
            end else begin
                in_valid = 1'b1; in_data = pix(idx, seed);
                #1;
                if (in_ready) begin
                    check("pos", {x_pos, y_pos}, {16'(idx % eff), 16'(idx / eff)});
                    e.data = pix(idx, seed);
                    e.sol  = (idx % eff == 0);
                    e.eol  = (idx % eff == eff - 1);
                    e.eof  = (idx == total - 1);
                    exp_q.push_back(e);
                    idx++;
                end
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        if (idx < total) check("frame_timeout", idx, total);
        guard = 0;
        while (mon_done == done0 && guard < eff + 20) begin
            @(negedge clock); #2;
            guard++;
        end
        check("done_seen", mon_done - done0, 1);
        check("flush_enables", mon_flush - flush0, eff);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clock); #2;
        check("done_one_cycle", {busy, done}, 0);
    endtask

    // Degenerate frame: straight to DONE with no bus activity.
    task automatic empty_frame(input int len, input int lines);
        int done0, act0;
        done0 = mon_done;
        act0  = mon_activity;
        @(negedge clock);
        start = 1'b1; length = 32'(len); num_lines = 16'(lines);
        @(negedge clock);
        start = 1'b0;
        #2;
        check("empty_busy_done", {busy, done}, 2'b11);
        @(negedge clock); #2;
        check("empty_idle", {busy, done}, 2'b00);
        repeat (3) @(negedge clock);
        #2;
        check("empty_done_count", mon_done - done0, 1);
        check("empty_no_activity", mon_activity - act0, 0);
    endtask

    initial begin
        bus.stall = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {bus.valid_out, bus.enable_out, bus.sol, bus.eol, bus.eof,
                                busy, done, in_ready}, 0);
        check("reset_pos", {x_pos, y_pos, 8'(bus.data_out)}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", in_ready, 1'b0);

        drive_frame(4,   2, 4,   -1, -1, -1, 1);   // basic 4x2 frame
        drive_frame(4,   2, 4,    2, -1, -1, 2);   // 3-cycle stall at x_pos=2
        drive_frame(6,   2, 6,   -1,  3, -1, 3);   // 2-cycle valid gap
        drive_frame(600, 1, 512, -1, -1, -1, 4);   // clamped line length
        empty_frame(0, 3);
        empty_frame(5, 0);
        drive_frame(4,   3, 4,   -1, -1,  7, 5);   // reset at x_pos=3, y_pos=1
        drive_frame(4,   3, 4,   -1, -1, -1, 6);   // fresh frame after abort

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
